// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a byte FIFO: pops one byte, then sends start, 8 data bits
// LSB first, optional even parity and 1 or 2 stop bits on a registered serial line.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       fifo_empty,
  output logic       fifo_rd_en,
  input  logic [7:0] fifo_rdata,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_POP    = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_START  = 3'd3;
  localparam logic [2:0] ST_DATA   = 3'd4;
  localparam logic [2:0] ST_PARITY = 3'd5;
  localparam logic [2:0] ST_STOP   = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [7:0]        shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              rd_en_q, rd_en_d;
  logic              done_q, done_d;
  logic              baud_last;

  assign baud_last = (baud_q == BAUD_LAST);

  // Next-state logic; outputs are derived from the next-state values so they register in step.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) state_d = ST_POP;
      end
      ST_POP: state_d = ST_LOAD;
      ST_LOAD: begin
        shift_d  = fifo_rdata;
        parity_d = ^fifo_rdata;
        baud_d   = '0;
        bit_d    = 3'd0;
        stop_d   = 1'b0;
        state_d  = ST_START;
      end
      ST_START: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = 3'd0;
            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = ST_STOP;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (stop_q == STOP_LAST) begin
            stop_d  = 1'b0;
            state_d = (enable && !fifo_empty) ? ST_POP : ST_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
      ST_PARITY: tx_d = parity_d;
      default:   tx_d = 1'b1;
    endcase

    busy_d  = (state_d != ST_IDLE);
    rd_en_d = (state_d == ST_POP);
    done_d  = (state_d == ST_STOP) && (baud_d == BAUD_LAST) && (stop_d == STOP_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      stop_q   <= 1'b0;
      shift_q  <= 8'd0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      rd_en_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      rd_en_q  <= rd_en_d;
      done_q   <= done_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_rd_en = rd_en_q;
  assign tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: one plain instance (8N1) and one with even parity
// and two stop bits, each fed by a small FIFO model; expected frames are hand-computed.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en0, en1;
  logic       empty0, empty1;
  logic       rd0, rd1;
  logic [7:0] rdata0 = 8'd0, rdata1 = 8'd0;
  logic       tx0, tx1, busy0, busy1, done0, done1;

  int passed = 0;
  int total  = 0;

  logic [7:0] mem0 [0:31];
  logic [7:0] mem1 [0:31];
  int head0 = 0, tail0 = 0, pops0 = 0, viol0 = 0;
  int head1 = 0, tail1 = 0, pops1 = 0, viol1 = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .STOP_BITS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .enable(en0), .fifo_empty(empty0), .fifo_rd_en(rd0),
    .fifo_rdata(rdata0), .tx(tx0), .busy(busy0), .tx_done(done0));

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .enable(en1), .fifo_empty(empty1), .fifo_rd_en(rd1),
    .fifo_rdata(rdata1), .tx(tx1), .busy(busy1), .tx_done(done1));

  // FIFO models: data appears the cycle after the pop request.
  assign empty0 = (head0 == tail0);
  assign empty1 = (head1 == tail1);

  always @(posedge clk) begin
    if (rd0) begin
      if (head0 == tail0) viol0 <= viol0 + 1;
      else begin
        rdata0 <= mem0[head0];
        head0  <= head0 + 1;
      end
      pops0 <= pops0 + 1;
    end
  end

  always @(posedge clk) begin
    if (rd1) begin
      if (head1 == tail1) viol1 <= viol1 + 1;
      else begin
        rdata1 <= mem1[head1];
        head1  <= head1 + 1;
      end
      pops1 <= pops1 + 1;
    end
  end

  typedef struct {
    int         d;
    logic [7:0] data;
    logic [11:0] bits;  // bit i = i-th transmitted bit time
    int         len;    // frame length in cycles
  } vec_t;

  function automatic logic get_tx(input int d);   return (d != 0) ? tx1 : tx0;     endfunction
  function automatic logic get_rd(input int d);   return (d != 0) ? rd1 : rd0;     endfunction
  function automatic logic get_busy(input int d); return (d != 0) ? busy1 : busy0; endfunction
  function automatic logic get_done(input int d); return (d != 0) ? done1 : done0; endfunction
  function automatic int   get_pops(input int d); return (d != 0) ? pops1 : pops0; endfunction

  task automatic set_en(input int d, input logic v);
    if (d != 0) en1 = v; else en0 = v;
  endtask

  task automatic push(input int d, input logic [7:0] b);
    if (d != 0) begin mem1[tail1] = b; tail1 = tail1 + 1; end
    else begin mem0[tail0] = b; tail0 = tail0 + 1; end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_pop(input int d, input string name);
    int n = 0;
    while (get_rd(d) !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, " pop seen"}, 32'(get_rd(d)), 32'd1);
  endtask

  // Called at the negedge of the POP cycle; leaves at the first start-bit cycle.
  task automatic gap(input int d, input string name);
    chk({name, " pop cycle tx/rd"}, 32'({get_tx(d), get_rd(d)}), 32'b11);
    @(negedge clk);
    chk({name, " load cycle tx/rd"}, 32'({get_tx(d), get_rd(d)}), 32'b10);
    @(negedge clk);
  endtask

  task automatic check_frame(input int d, input logic [11:0] bits, input int len,
                             input string name, input int drop_at);
    int nbits;
    int flag_bad;
    logic [31:0] got;
    logic [31:0] want;
    nbits = len / CPB;
    flag_bad = 0;
    for (int b = 0; b < nbits; b++) begin
      got  = '0;
      want = '0;
      for (int k = 0; k < CPB; k++) begin
        if (b * CPB + k == drop_at) set_en(d, 1'b0);
        got[k]  = get_tx(d);
        want[k] = bits[b];
        if (get_done(d) !== ((b * CPB + k) == (len - 1))) flag_bad++;
        if (get_busy(d) !== 1'b1) flag_bad++;
        @(negedge clk);
      end
      chk($sformatf("%s bit%0d tx", name, b), got, want);
    end
    chk({name, " done/busy bad cycles"}, 32'(flag_bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   p0;
    vecs[0] = '{d: 0, data: 8'hA5, bits: 12'b001101001010, len: 40};
    vecs[1] = '{d: 0, data: 8'h3C, bits: 12'b001001111000, len: 40};
    vecs[2] = '{d: 1, data: 8'h07, bits: 12'b111000001110, len: 48};
    vecs[3] = '{d: 1, data: 8'h5A, bits: 12'b110010110100, len: 48};

    // Reset held with a non-empty FIFO and enable high.
    rst_n = 1'b0;
    en0 = 1'b1;
    en1 = 1'b0;
    push(0, 8'h99);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("reset outputs {tx,busy,rd,done}", 32'({tx0, busy0, rd0, done0}), 32'b1000);
    end
    en0 = 1'b0;
    tail0 = head0;
    rst_n = 1'b1;
    @(negedge clk);

    // Single frames from the table.
    for (int i = 0; i < 4; i++) begin
      p0 = get_pops(vecs[i].d);
      push(vecs[i].d, vecs[i].data);
      set_en(vecs[i].d, 1'b1);
      wait_pop(vecs[i].d, $sformatf("vec%0d", i));
      set_en(vecs[i].d, 1'b0);
      gap(vecs[i].d, $sformatf("vec%0d", i));
      check_frame(vecs[i].d, vecs[i].bits, vecs[i].len, $sformatf("vec%0d", i), -1);
      chk($sformatf("vec%0d busy after", i), 32'(get_busy(vecs[i].d)), 32'd0);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d pop count", i), 32'(get_pops(vecs[i].d) - p0), 32'd1);
    end

    // Back-to-back: 0x00 then 0xFF with the 2-cycle POP/LOAD gap.
    p0 = pops0;
    push(0, 8'h00);
    push(0, 8'hFF);
    en0 = 1'b1;
    wait_pop(0, "b2b first");
    gap(0, "b2b first");
    check_frame(0, 12'b001000000000, 40, "b2b 0x00", -1);
    gap(0, "b2b second");
    check_frame(0, 12'b001111111110, 40, "b2b 0xFF", -1);
    repeat (10) @(negedge clk);
    chk("b2b busy after", 32'(busy0), 32'd0);
    chk("b2b pop count", 32'(pops0 - p0), 32'd2);
    en0 = 1'b0;

    // Enable dropped during DATA of the first of three queued bytes.
    p0 = pops0;
    push(0, 8'h11);
    push(0, 8'h22);
    push(0, 8'h33);
    en0 = 1'b1;
    wait_pop(0, "drop");
    gap(0, "drop");
    check_frame(0, 12'b001000100010, 40, "drop 0x11", 12);
    repeat (20) @(negedge clk);
    chk("drop idle busy", 32'(busy0), 32'd0);
    chk("drop no further pop", 32'(pops0 - p0), 32'd1);
    en0 = 1'b1;
    wait_pop(0, "resume");
    en0 = 1'b0;
    gap(0, "resume");
    check_frame(0, 12'b001001000100, 40, "resume 0x22", -1);
    repeat (5) @(negedge clk);
    chk("resume pop count", 32'(pops0 - p0), 32'd2);

    // Reset pulsed in the middle of data bit 3 of 0x33.
    push(0, 8'hC3);
    en0 = 1'b1;
    wait_pop(0, "midrst");
    gap(0, "midrst");
    repeat (17) @(negedge clk);
    chk("midrst tx before reset (bit3 of 0x33)", 32'(tx0), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("midrst async {tx,busy,rd,done}", 32'({tx0, busy0, rd0, done0}), 32'b1000);
    @(negedge clk);
    chk("midrst held {tx,busy,rd,done}", 32'({tx0, busy0, rd0, done0}), 32'b1000);
    rst_n = 1'b1;
    wait_pop(0, "after reset");
    gap(0, "after reset");
    check_frame(0, 12'b001110000110, 40, "after reset 0xC3", -1);
    en0 = 1'b0;
    repeat (5) @(negedge clk);
    chk("after reset busy", 32'(busy0), 32'd0);

    chk("rd_en while empty", 32'(viol0 + viol1), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
